// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock/tick generator running off sysclk.
// Each channel has a run-time divisor with glitch-free shadow update, enable, square/tick mode and a global sync.
module clock_divider_multi #(
  parameter int          N_CH        = 2,
  parameter int          CNT_W       = 24,
  parameter int unsigned DEFAULT_DIV = 6000
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic [N_CH-1:0]  mode,
  input  logic [N_CH-1:0]  div_wr,
  input  logic [CNT_W-1:0] div_data,
  input  logic             sync,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pend
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] active_div [N_CH];
  logic [CNT_W-1:0] shadow_div [N_CH];
  logic [CNT_W-1:0] cnt        [N_CH];
  logic [CNT_W-1:0] last       [N_CH];
  logic [N_CH-1:0]  wrap;

  // A stored divisor of 0 behaves as 1, so the terminal count is 0 in both cases.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      last[i] = (active_div[i] == '0) ? '0 : active_div[i] - 1'b1;
      wrap[i] = en[i] && (cnt[i] >= last[i]);
    end
  end

  always_ff @(posedge sysclk) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rst) begin
        cnt[i]        <= '0;
        clk_out[i]    <= 1'b0;
        tick[i]       <= 1'b0;
        pend[i]       <= 1'b0;
        active_div[i] <= RST_DIV;
        shadow_div[i] <= RST_DIV;
      end else if (sync || !en[i]) begin
        // Immediate application: a direct write beats a pending shadow value.
        cnt[i]     <= '0;
        clk_out[i] <= 1'b0;
        tick[i]    <= 1'b0;
        pend[i]    <= 1'b0;
        if (div_wr[i])
          active_div[i] <= div_data;
        else if (pend[i])
          active_div[i] <= shadow_div[i];
      end else if (wrap[i]) begin
        cnt[i]     <= '0;
        clk_out[i] <= mode[i] ? 1'b0 : ~clk_out[i];
        tick[i]    <= mode[i];
        pend[i]    <= 1'b0;
        if (div_wr[i]) begin
          active_div[i] <= div_data;
          shadow_div[i] <= div_data;
        end else if (pend[i]) begin
          active_div[i] <= shadow_div[i];
        end
      end else begin
        cnt[i]  <= cnt[i] + 1'b1;
        tick[i] <= 1'b0;
        if (mode[i])
          clk_out[i] <= 1'b0;
        if (div_wr[i]) begin
          shadow_div[i] <= div_data;
          pend[i]       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi: vector table, hand-written corner sequences
// and randomized stimulus against a countdown-based reference model.
`timescale 1ns/1ps
module tb_clock_divider_multi;

  localparam int NC = 2;

  logic          sysclk = 1'b0;
  logic          rst;
  logic [NC-1:0] en, mode, div_wr;
  logic [23:0]   div_data;
  logic          sync;
  logic [NC-1:0] clk_out, tick, pend;

  int tests  = 0;
  int failed = 0;

  clock_divider_multi #(.N_CH(NC), .CNT_W(24), .DEFAULT_DIV(6000)) dut (
    .sysclk(sysclk), .rst(rst), .en(en), .mode(mode), .div_wr(div_wr),
    .div_data(div_data), .sync(sync), .clk_out(clk_out), .tick(tick), .pend(pend)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: cycles left until the next wrap, plus divisor bookkeeping.
  int m_div [NC];
  int m_sh  [NC];
  int m_left[NC];
  bit m_pend[NC];
  bit m_clk [NC];
  bit m_tick[NC];

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic void model_step(input bit r, input bit [1:0] e, input bit [1:0] m,
                                     input bit [1:0] w, input int d, input bit s);
    for (int c = 0; c < NC; c++) begin
      if (r) begin
        m_div[c] = 6000; m_sh[c] = 6000; m_pend[c] = 0;
        m_left[c] = 6000; m_clk[c] = 0; m_tick[c] = 0;
      end else if (s || !e[c]) begin
        if (w[c]) m_div[c] = d;
        else if (m_pend[c]) m_div[c] = m_sh[c];
        m_pend[c] = 0; m_left[c] = eff(m_div[c]); m_clk[c] = 0; m_tick[c] = 0;
      end else begin
        m_left[c] = m_left[c] - 1;
        if (m_left[c] == 0) begin
          if (w[c]) m_div[c] = d;
          else if (m_pend[c]) m_div[c] = m_sh[c];
          m_pend[c] = 0;
          m_left[c] = eff(m_div[c]);
          m_tick[c] = m[c];
          m_clk[c]  = m[c] ? 1'b0 : ~m_clk[c];
        end else begin
          m_tick[c] = 0;
          if (m[c]) m_clk[c] = 0;
          if (w[c]) begin m_sh[c] = d; m_pend[c] = 1; end
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit [1:0] e, input bit [1:0] m,
                      input bit [1:0] w, input int d, input bit s);
    logic [7:0] exp;
    rst = r; en = e; mode = m; div_wr = w; div_data = d[23:0]; sync = s;
    model_step(r, e, m, w, d, s);
    @(posedge sysclk);
    #1;
    exp = {2'b00, m_clk[1], m_clk[0], m_tick[1], m_tick[0], m_pend[1], m_pend[0]};
    check("model", {2'b00, clk_out, tick, pend}, exp);
  endtask

  typedef struct {
    bit       r;
    bit [1:0] e, m, w;
    int       d;
    bit       s;
    bit [1:0] xclk, xtick, xpend;
  } vec_t;

  vec_t tbl[14];

  initial begin
    bit [1:0] rm;
    rst = 1'b1; en = '0; mode = '0; div_wr = '0; div_data = '0; sync = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;

    // Square mode D=3 on channel 0, then a pending write that lands on the next wrap.
    tbl[0]  = '{1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{0, 2'b00, 2'b00, 2'b01, 3, 0, 2'b00, 2'b00, 2'b00};
    tbl[2]  = '{0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00};
    tbl[3]  = '{0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00};
    tbl[4]  = '{0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00};
    tbl[5]  = '{0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00};
    tbl[6]  = '{0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00};
    tbl[7]  = '{0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00};
    tbl[8]  = '{0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00};
    tbl[9]  = '{0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00};
    tbl[10] = '{0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00};
    tbl[11] = '{0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00};
    tbl[12] = '{0, 2'b01, 2'b00, 2'b01, 3, 0, 2'b01, 2'b00, 2'b01};
    tbl[13] = '{0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].w, tbl[i].d, tbl[i].s);
      check($sformatf("vec%0d", i), {2'b00, clk_out, tick, pend},
            {2'b00, tbl[i].xclk, tbl[i].xtick, tbl[i].xpend});
    end

    // Tick mode D=4: one pulse every 4 cycles, first on the 4th enabled cycle.
    step(1, 2'b00, 2'b00, 2'b00, 0, 0);
    step(0, 2'b00, 2'b00, 2'b01, 4, 0);
    for (int s = 1; s <= 12; s++) begin
      step(0, 2'b01, 2'b01, 2'b00, 0, 0);
      check($sformatf("tick_d4_s%0d", s), {4'b0, tick, clk_out}, (s % 4 == 0) ? 8'h04 : 8'h00);
    end

    // Square D=5, write 2 at cnt=1: old half-period completes, then 2-cycle halves.
    step(1, 2'b00, 2'b00, 2'b00, 0, 0);
    step(0, 2'b00, 2'b00, 2'b01, 5, 0);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0);
    step(0, 2'b01, 2'b00, 2'b01, 2, 0);
    check("d5_pend_set", {7'b0, pend[0]}, 8'd1);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0);
    check("d5_s4", {6'b0, clk_out[0], pend[0]}, 8'b01);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0);
    check("d5_s5", {6'b0, clk_out[0], pend[0]}, 8'b10);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0);
    check("d2_s6", {7'b0, clk_out[0]}, 8'd1);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0);
    check("d2_s7", {7'b0, clk_out[0]}, 8'd0);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0);
    check("d2_s9", {7'b0, clk_out[0]}, 8'd1);
    // Write 7 in the exact wrap cycle: applies at once, pend never rises.
    step(0, 2'b01, 2'b00, 2'b00, 0, 0);
    step(0, 2'b01, 2'b00, 2'b01, 7, 0);
    check("wrapwr_s11", {6'b0, clk_out[0], pend[0]}, 8'b00);
    for (int s = 12; s <= 18; s++) begin
      step(0, 2'b01, 2'b00, 2'b00, 0, 0);
      check($sformatf("d7_s%0d", s), {6'b0, clk_out[0], pend[0]}, (s == 18) ? 8'b10 : 8'b00);
    end

    // D=0 behaves as D=1: square toggles every cycle, tick constantly high.
    step(0, 2'b00, 2'b00, 2'b01, 0, 0);
    for (int s = 1; s <= 3; s++) begin
      step(0, 2'b01, 2'b00, 2'b00, 0, 0);
      check($sformatf("d0_sq_s%0d", s), {7'b0, clk_out[0]}, 8'(s % 2));
    end
    for (int s = 1; s <= 3; s++) begin
      step(0, 2'b01, 2'b01, 2'b00, 0, 0);
      check($sformatf("d0_tick_s%0d", s), {6'b0, tick[0], clk_out[0]}, 8'b10);
    end

    // Sync with D=3 and D=6 mid-period, then phase-aligned wraps.
    step(1, 2'b00, 2'b00, 2'b00, 0, 0);
    step(0, 2'b00, 2'b00, 2'b01, 3, 0);
    step(0, 2'b00, 2'b00, 2'b10, 6, 0);
    for (int s = 0; s < 4; s++) step(0, 2'b11, 2'b00, 2'b00, 0, 0);
    step(0, 2'b11, 2'b00, 2'b00, 0, 1);
    check("sync_out0", {4'b0, clk_out, tick}, 8'h00);
    for (int s = 1; s <= 24; s++) begin
      step(0, 2'b11, 2'b00, 2'b00, 0, 0);
      check($sformatf("sync_s%0d", s), {6'b0, clk_out}, {6'b0, 1'((s / 6) % 2), 1'((s / 3) % 2)});
    end
    // Pending write on ch1 applied by sync; sync+div_wr on ch0 writes directly.
    step(0, 2'b11, 2'b00, 2'b10, 2, 0);
    check("pre_sync_pend", {6'b0, pend}, 8'b10);
    step(0, 2'b11, 2'b00, 2'b01, 2, 1);
    check("sync_wr", {2'b0, clk_out, tick, pend}, 8'h00);
    step(0, 2'b11, 2'b00, 2'b00, 0, 0);
    check("sync_wr_s1", {6'b0, clk_out}, 8'b00);
    step(0, 2'b11, 2'b00, 2'b00, 0, 0);
    check("sync_wr_s2", {6'b0, clk_out}, 8'b11);

    // Reset mid-high phase with a pending write, then default 6000 divisor.
    step(0, 2'b11, 2'b00, 2'b01, 5, 0);
    check("pre_rst", {4'b0, clk_out, pend}, 8'b1101);
    step(1, 2'b11, 2'b00, 2'b00, 0, 0);
    check("rst_out", {2'b0, clk_out, tick, pend}, 8'h00);
    for (int s = 1; s <= 12000; s++) begin
      step(0, 2'b01, 2'b00, 2'b00, 0, 0);
      if (s == 5999 || s == 6000 || s == 11999 || s == 12000)
        check($sformatf("d6000_s%0d", s), {7'b0, clk_out[0]},
              (s == 6000 || s == 11999) ? 8'd1 : 8'd0);
    end

    // Randomized traffic against the model.
    step(1, 2'b00, 2'b00, 2'b00, 0, 0);
    rm = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      bit       r, s;
      bit [1:0] e, w;
      r = ($urandom_range(0, 399) == 0);
      s = ($urandom_range(0, 99) == 0);
      for (int c = 0; c < NC; c++) begin
        e[c] = ($urandom_range(0, 9) != 0);
        w[c] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 49) == 0) rm[c] = ~rm[c];
      end
      step(r, e, rm, w, int'($urandom_range(0, 7)), s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
